// File: rtl/series_operand_feeder_pkg.sv
// rtl/series_operand_feeder_pkg.sv - shared widths, FSM state codes and byte index codes
package series_operand_feeder_pkg;

    localparam int X_W_DEF = 16;
    localparam int Y_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } feeder_state_t;

    typedef enum logic [1:0] {
        IDX_XLO = 2'd0,
        IDX_XHI = 2'd1,
        IDX_Y   = 2'd2
    } byte_idx_t;

endpackage

// File: rtl/series_operand_feeder_job_fifo.sv
// rtl/series_operand_feeder_job_fifo.sv - synchronous job FIFO with flush and occupancy count
module series_operand_feeder_job_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // full/empty come from the registered count, so a same-cycle pop never frees a slot for a push
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && rst && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/series_operand_feeder.sv
// rtl/series_operand_feeder.sv - byte-stream job assembler, job FIFO and launch/wait FSM
module series_operand_feeder
    import series_operand_feeder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int X_W   = X_W_DEF,
    parameter int Y_W   = Y_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    input  logic                     done,
    output logic [X_W-1:0]           xin,
    output logic [Y_W-1:0]           yin,
    output logic                     start,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int JW = X_W + Y_W;

    byte_idx_t     byte_idx;
    feeder_state_t state;
    logic [7:0]    x_lo;
    logic [7:0]    x_hi;
    logic          accept;
    logic          push;
    logic          pop;
    logic [JW-1:0] head;

    assign byte_ready = (byte_idx != IDX_Y) | ~full;
    assign accept     = byte_valid & byte_ready & ~flush;
    assign push       = accept & (byte_idx == IDX_Y);
    assign pop        = (state == ST_IDLE) & ~empty & ~flush;

    series_operand_feeder_job_fifo #(
        .DEPTH (DEPTH),
        .W     (JW)
    ) u_job_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (JW'({x_hi, x_lo, byte_in})),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Partial jobs live only in x_lo/x_hi and byte_idx, so rst/flush simply discard them
    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_idx <= IDX_XLO;
            x_lo     <= '0;
            x_hi     <= '0;
        end else if (flush) begin
            byte_idx <= IDX_XLO;
        end else if (accept) begin
            case (byte_idx)
                IDX_XLO: begin
                    x_lo     <= byte_in;
                    byte_idx <= IDX_XHI;
                end
                IDX_XHI: begin
                    x_hi     <= byte_in;
                    byte_idx <= IDX_Y;
                end
                default: byte_idx <= IDX_XLO;
            endcase
        end
    end

    // xin/yin load only on a pop and deliberately survive flush
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            xin   <= '0;
            yin   <= '0;
            start <= 1'b0;
            busy  <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
            start <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        xin   <= head[JW-1:Y_W];
                        yin   <= head[Y_W-1:0];
                        start <= 1'b1;
                        busy  <= 1'b1;
                        state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    start <= 1'b0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    start <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_series_operand_feeder.sv
// tb/tb_series_operand_feeder.sv - directed and randomized bench against a job-queue reference model
module tb_series_operand_feeder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        done;
    logic [15:0] xin;
    logic [7:0]  yin;
    logic        start;
    logic        busy;
    logic        full;
    logic        empty;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    // reference model: byte position, pending jobs, and what the controller interface shows
    int          m_idx;
    logic [7:0]  m_xlo;
    logic [7:0]  m_xhi;
    logic [23:0] m_q[$];
    logic        m_start;
    logic        m_busy;
    logic [15:0] m_xin;
    logic [7:0]  m_yin;

    series_operand_feeder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .done       (done),
        .xin        (xin),
        .yin        (yin),
        .start      (start),
        .busy       (busy),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        return (m_idx != 2) || (m_q.size() < DEPTH);
    endfunction

    task automatic check_all();
        check_eq("start", 32'(start), 32'(m_start));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("xin", 32'(xin), 32'(m_xin));
        check_eq("yin", 32'(yin), 32'(m_yin));
        check_eq("count", 32'(count), 32'(m_q.size()));
        check_eq("full", 32'(full), 32'(m_q.size() == DEPTH));
        check_eq("empty", 32'(empty), 32'(m_q.size() == 0));
        check_eq("byte_ready", 32'(byte_ready), 32'(model_ready()));
    endtask

    // one clock: drive inputs, advance the model at the edge, compare on the falling edge
    task automatic step(input logic bv, input logic [7:0] b, input logic d,
                        input logic fl, input logic rs, output logic acc);
        logic        rdy;
        logic [23:0] job;
        byte_valid = bv;
        byte_in    = b;
        done       = d;
        flush      = fl;
        rst        = rs;
        acc        = 1'b0;
        @(posedge clk);
        if (!rs) begin
            m_idx = 0; m_q.delete(); m_start = 0; m_busy = 0; m_xin = '0; m_yin = '0;
        end else if (fl) begin
            m_idx = 0; m_q.delete(); m_start = 0; m_busy = 0;
        end else begin
            rdy = model_ready();
            if (!m_busy && m_q.size() > 0) begin
                job = m_q.pop_front();
                m_xin = job[23:8]; m_yin = job[7:0]; m_start = 1; m_busy = 1;
            end else if (m_start) begin
                m_start = 0;
            end else if (m_busy && d) begin
                m_busy = 0;
            end
            if (bv && rdy) begin
                acc = 1'b1;
                if (m_idx == 0) m_xlo = b;
                else if (m_idx == 1) m_xhi = b;
                else m_q.push_back({m_xhi, m_xlo, b});
                m_idx = (m_idx + 1) % 3;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic feed_bytes(input int n, input logic d);
        int   sent = 0;
        logic acc;
        for (int cyc = 0; cyc < 4 * n + 20 && sent < n; cyc++) begin
            step(1'b1, 8'($urandom), d, 1'b0, 1'b1, acc);
            if (acc) sent++;
        end
        check_eq("feed_done", 32'(sent), 32'(n));
    endtask

    initial begin
        logic acc;
        int   guard;
        m_idx = 0; m_xlo = '0; m_xhi = '0; m_start = 0; m_busy = 0; m_xin = '0; m_yin = '0;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        check_eq("rst_ready", 32'(byte_ready), 32'd1);
        check_eq("rst_empty", 32'(empty), 32'd1);

        step(1'b1, 8'h34, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 8'h05, 1'b0, 1'b0, 1'b1, acc);
        check_eq("t1_no_start_yet", 32'(start), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        check_eq("t1_start", 32'(start), 32'd1);
        check_eq("t1_xin", 32'(xin), 32'h1234);
        check_eq("t1_yin", 32'(yin), 32'h05);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);
        check_eq("t3_done_in_launch", 32'(busy), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);
        check_eq("t3_done_in_wait", 32'(busy), 32'd0);

        feed_bytes(15, 1'b0);
        check_eq("t2_full", 32'(full), 32'd1);
        check_eq("t2_count", 32'(count), 32'd4);
        feed_bytes(2, 1'b0);
        check_eq("t2_ready_blocked", 32'(byte_ready), 32'd0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, acc);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, acc);
        check_eq("t4_push_refused", 32'(acc), 32'd0);
        check_eq("t4_count_after_pop", 32'(count), 32'd3);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, acc);
        check_eq("t4_count_refill", 32'(count), 32'd4);
        guard = 0;
        while ((m_busy || m_q.size() > 0) && guard < 80) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);
            guard++;
        end
        check_eq("drain_idle", 32'(busy || !empty), 32'd0);

        feed_bytes(11, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b1, acc);
        check_eq("t5_count", 32'(count), 32'd0);
        check_eq("t5_empty", 32'(empty), 32'd1);
        check_eq("t5_busy", 32'(busy), 32'd0);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        check_eq("t5_start", 32'(start), 32'd1);
        check_eq("t5_xin", 32'(xin), 32'hBBAA);
        check_eq("t5_yin", 32'(yin), 32'hCC);

        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, acc);
        check_eq("t6_xin", 32'(xin), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);

        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 10) < 7, 8'($urandom), ($urandom % 5) == 0,
                 ($urandom % 64) == 0, ($urandom % 128) != 0, acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
